// File: rtl/uart_frame_pkg.sv
// Shared encodings for the UART frame controller: FSM states, error codes
// and the default frame start marker.
package uart_frame_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ADDR   = 3'd1,
        ST_LEN    = 3'd2,
        ST_DATA   = 3'd3,
        ST_CHK    = 3'd4,
        ST_COMMIT = 3'd5
    } state_e;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_CHK  = 2'b01;
    localparam logic [1:0] ERR_LEN  = 2'b10;
    localparam logic [1:0] ERR_TMO  = 2'b11;

    localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

endpackage

// File: rtl/uart_frame_ctrl_if.sv
// Byte-in / register-write-out signal bundle of the frame controller.
// master drives received bytes, slave is the controller side.
interface uart_frame_ctrl_if;

    logic       rx_dv;
    logic [7:0] rx_byte;
    logic       wr_en;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       frame_done;
    logic       frame_err;
    logic [1:0] err_code;
    logic       busy;

    modport master (
        output rx_dv, rx_byte,
        input  wr_en, wr_addr, wr_data, frame_done, frame_err, err_code, busy
    );

    modport slave (
        input  rx_dv, rx_byte,
        output wr_en, wr_addr, wr_data, frame_done, frame_err, err_code, busy
    );

endinterface

// File: rtl/uart_frame_buf.sv
// Payload store: DEPTH x 8 register file, one synchronous write port and
// one combinational read port.
module uart_frame_buf #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/uart_frame_ctrl.sv
// Parses SYNC/ADDR/LEN/DATA/CHK frames from a UART byte stream and, on a
// good XOR checksum, replays the payload as consecutive register writes.
module uart_frame_ctrl
    import uart_frame_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE    = SYNC_DEFAULT,
    parameter int         MAX_LEN      = 16,
    parameter int         TIMEOUT_CLKS = 20000
) (
    input  logic       i_Clock,
    input  logic       i_Reset_n,
    input  logic       i_Rx_DV,
    input  logic [7:0] i_Rx_Byte,
    output logic       o_Wr_En,
    output logic [7:0] o_Wr_Addr,
    output logic [7:0] o_Wr_Data,
    output logic       o_Frame_Done,
    output logic       o_Frame_Err,
    output logic [1:0] o_Err_Code,
    output logic       o_Busy
);

    localparam int IW = $clog2(MAX_LEN + 1);
    localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int TW = $clog2(TIMEOUT_CLKS);
    localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);
    // Expires on the edge where the counter would reach TIMEOUT_CLKS-1.
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CLKS - 2);

    state_e        state_q, state_d;
    logic [7:0]    addr_q, addr_d;
    logic [7:0]    xor_q, xor_d;
    logic [IW-1:0] len_q, len_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [TW-1:0] cnt_q, cnt_d;
    logic [1:0]    err_code_q, err_code_d;
    logic          frame_err_q, frame_err_d;

    logic          buf_we;
    logic [7:0]    buf_rdata;
    logic          in_frame, tmo_hit, committing, last_wr;

    assign in_frame   = state_q inside {ST_ADDR, ST_LEN, ST_DATA, ST_CHK};
    assign committing = (state_q == ST_COMMIT);
    assign tmo_hit    = in_frame && !i_Rx_DV && (cnt_q == TMO_LAST);
    assign last_wr    = committing && (idx_q == len_q - IW'(1));

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        xor_d       = xor_q;
        len_d       = len_q;
        idx_d       = idx_q;
        err_code_d  = err_code_q;
        frame_err_d = 1'b0;
        buf_we      = 1'b0;
        cnt_d       = (in_frame && !i_Rx_DV) ? cnt_q + 1'b1 : '0;

        case (state_q)
            ST_IDLE: begin
                if (i_Rx_DV && i_Rx_Byte == SYNC_BYTE) state_d = ST_ADDR;
            end
            ST_ADDR: begin
                if (i_Rx_DV) begin
                    addr_d  = i_Rx_Byte;
                    xor_d   = i_Rx_Byte;
                    state_d = ST_LEN;
                end
            end
            ST_LEN: begin
                if (i_Rx_DV) begin
                    if (i_Rx_Byte != 8'h00 && i_Rx_Byte <= MAX_LEN_B) begin
                        len_d   = IW'(i_Rx_Byte);
                        xor_d   = xor_q ^ i_Rx_Byte;
                        idx_d   = '0;
                        state_d = ST_DATA;
                    end else begin
                        err_code_d  = ERR_LEN;
                        frame_err_d = 1'b1;
                        state_d     = ST_IDLE;
                    end
                end
            end
            ST_DATA: begin
                if (i_Rx_DV) begin
                    buf_we = 1'b1;
                    xor_d  = xor_q ^ i_Rx_Byte;
                    idx_d  = idx_q + 1'b1;
                    if (idx_q == len_q - IW'(1)) state_d = ST_CHK;
                end
            end
            ST_CHK: begin
                if (i_Rx_DV) begin
                    if ((xor_q ^ i_Rx_Byte) == 8'h00) begin
                        idx_d   = '0;
                        state_d = ST_COMMIT;
                    end else begin
                        err_code_d  = ERR_CHK;
                        frame_err_d = 1'b1;
                        state_d     = ST_IDLE;
                    end
                end
            end
            ST_COMMIT: begin
                // Bytes arriving here are dropped; the replay runs on its own.
                idx_d = idx_q + 1'b1;
                if (last_wr) begin
                    idx_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (tmo_hit) begin
            err_code_d  = ERR_TMO;
            frame_err_d = 1'b1;
            cnt_d       = '0;
            state_d     = ST_IDLE;
        end
    end

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            xor_q       <= '0;
            len_q       <= '0;
            idx_q       <= '0;
            cnt_q       <= '0;
            err_code_q  <= ERR_NONE;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            xor_q       <= xor_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            err_code_q  <= err_code_d;
            frame_err_q <= frame_err_d;
        end
    end

    uart_frame_buf #(.DEPTH(MAX_LEN), .AW(AW)) u_buf (
        .clk   (i_Clock),
        .we    (buf_we),
        .waddr (idx_q[AW-1:0]),
        .wdata (i_Rx_Byte),
        .raddr (idx_q[AW-1:0]),
        .rdata (buf_rdata)
    );

    // Write bus is forced to zero outside COMMIT so idle/reset values are clean.
    assign o_Wr_En      = committing;
    assign o_Wr_Addr    = committing ? addr_q + 8'(idx_q) : 8'h00;
    assign o_Wr_Data    = committing ? buf_rdata : 8'h00;
    assign o_Frame_Done = last_wr;
    assign o_Frame_Err  = frame_err_q;
    assign o_Err_Code   = err_code_q;
    assign o_Busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// Randomized frame streams checked every cycle against a byte-queue model,
// plus directed frames with hand-computed write/error expectations.
module tb_uart_frame_ctrl;

    localparam logic [7:0] SYNC = 8'hA5;
    localparam int MAXL = 16;
    localparam int TMO  = 40;

    typedef struct {
        logic [7:0] a;
        logic [7:0] d;
    } wr_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_frame_ctrl_if bus();

    uart_frame_ctrl #(.SYNC_BYTE(SYNC), .MAX_LEN(MAXL), .TIMEOUT_CLKS(TMO)) dut (
        .i_Clock      (clk),
        .i_Reset_n    (rst_n),
        .i_Rx_DV      (bus.rx_dv),
        .i_Rx_Byte    (bus.rx_byte),
        .o_Wr_En      (bus.wr_en),
        .o_Wr_Addr    (bus.wr_addr),
        .o_Wr_Data    (bus.wr_data),
        .o_Frame_Done (bus.frame_done),
        .o_Frame_Err  (bus.frame_err),
        .o_Err_Code   (bus.err_code),
        .o_Busy       (bus.busy)
    );

    int n_chk = 0;
    int n_pass = 0;
    int n_done_seen = 0;
    int n_err_seen = 0;

    // Model: frame bytes after SYNC are collected in fr; a good frame turns
    // into a queue of pending writes that drains one per cycle.
    bit         m_in_frame = 1'b0;
    bit         m_commit = 1'b0;
    bit         m_err = 1'b0;
    logic [1:0] m_code = 2'b00;
    int         m_gap = 0;
    logic [7:0] fr[$];
    wr_t        wq[$];

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    task automatic model_reset();
        m_in_frame = 1'b0;
        m_commit   = 1'b0;
        m_err      = 1'b0;
        m_code     = 2'b00;
        m_gap      = 0;
        fr.delete();
        wq.delete();
    endtask

    task automatic model_abort(input logic [1:0] code);
        m_err      = 1'b1;
        m_code     = code;
        m_in_frame = 1'b0;
    endtask

    task automatic model_step(input bit dv, input logic [7:0] b);
        logic [7:0] x;
        wr_t w;
        m_err = 1'b0;
        if (!rst_n) begin
            model_reset();
        end else if (m_commit) begin
            void'(wq.pop_front());
            if (wq.size() == 0) m_commit = 1'b0;
        end else if (m_in_frame) begin
            if (dv) begin
                fr.push_back(b);
                m_gap = 0;
                if (fr.size() == 2 && (b == 8'h00 || int'(b) > MAXL)) begin
                    model_abort(2'b10);
                end else if (fr.size() >= 3 && fr.size() == int'(fr[1]) + 3) begin
                    x = 8'h00;
                    foreach (fr[i]) x ^= fr[i];
                    if (x == 8'h00) begin
                        for (int i = 0; i < int'(fr[1]); i++) begin
                            w.a = fr[0] + 8'(i);
                            w.d = fr[2+i];
                            wq.push_back(w);
                        end
                        m_commit   = 1'b1;
                        m_in_frame = 1'b0;
                    end else begin
                        model_abort(2'b01);
                    end
                end
            end else begin
                m_gap++;
                if (m_gap == TMO - 1) model_abort(2'b11);
            end
        end else if (dv && b == SYNC) begin
            m_in_frame = 1'b1;
            m_gap      = 0;
            fr.delete();
        end
    endtask

    always @(negedge clk) begin
        bit ew, edn, eb;
        logic [7:0] ea, ed;
        ew  = m_commit;
        ea  = ew ? wq[0].a : 8'h00;
        ed  = ew ? wq[0].d : 8'h00;
        edn = ew && (wq.size() == 1);
        eb  = m_in_frame || m_commit;
        chk("wr_en",      8'(bus.wr_en),      8'(ew));
        chk("wr_addr",    bus.wr_addr,        ea);
        chk("wr_data",    bus.wr_data,        ed);
        chk("frame_done", 8'(bus.frame_done), 8'(edn));
        chk("frame_err",  8'(bus.frame_err),  8'(m_err));
        chk("err_code",   8'(bus.err_code),   8'(m_code));
        chk("busy",       8'(bus.busy),       8'(eb));
        if (bus.frame_done === 1'b1) n_done_seen++;
        if (bus.frame_err === 1'b1) n_err_seen++;
    end

    task automatic tick(input bit dv, input logic [7:0] b);
        bus.rx_dv   = dv;
        bus.rx_byte = b;
        @(posedge clk);
        model_step(dv, b);
        #1;
    endtask

    task automatic send_bytes(input logic [7:0] q[$]);
        foreach (q[i]) begin
            tick(1'b1, q[i]);
            tick(1'b0, 8'h00);
        end
    endtask

    function automatic int pick_gap();
        int r;
        r = $urandom_range(0, 99);
        if (r < 3) return TMO - 2;
        if (r < 5) return TMO - 1;
        return $urandom_range(0, 2);
    endfunction

    task automatic rand_frame();
        logic [7:0] q[$];
        logic [7:0] a, l, x, d, j;
        int kind, g;
        kind = $urandom_range(0, 9);
        a = 8'($urandom);
        l = 8'($urandom_range(1, MAXL));
        if (kind == 9) l = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(MAXL + 1, 255));
        q = {SYNC, a, l};
        x = a ^ l;
        for (int i = 0; i < int'(l) && i < MAXL; i++) begin
            d = 8'($urandom);
            q.push_back(d);
            x ^= d;
        end
        if (kind == 8) x ^= 8'($urandom_range(1, 255));
        q.push_back(x);
        foreach (q[i]) begin
            tick(1'b1, q[i]);
            g = pick_gap();
            repeat (g) tick(1'b0, 8'($urandom));
        end
        repeat ($urandom_range(0, MAXL + 4)) begin
            j = 8'($urandom);
            if (j == SYNC) j = 8'h00;
            tick($urandom_range(0, 4) == 0, j);
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    initial begin
        logic [7:0] q[$];
        int k, done_before;
        bus.rx_dv   = 1'b0;
        bus.rx_byte = 8'h00;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_wr_en",    8'(bus.wr_en),    8'h00);
        chk("rst_err_code", 8'(bus.err_code), 8'h00);
        chk("rst_busy",     8'(bus.busy),     8'h00);
        rst_n = 1'b1;
        tick(1'b0, 8'h00);

        // Good frame.
        q = {8'hA5, 8'h10, 8'h02, 8'h11, 8'h22};
        send_bytes(q);
        tick(1'b1, 8'h21);
        chk("good_w0_en",   8'(bus.wr_en),      8'h01);
        chk("good_w0_addr", bus.wr_addr,        8'h10);
        chk("good_w0_data", bus.wr_data,        8'h11);
        chk("good_w0_done", 8'(bus.frame_done), 8'h00);
        tick(1'b0, 8'h00);
        chk("good_w1_addr", bus.wr_addr,        8'h11);
        chk("good_w1_data", bus.wr_data,        8'h22);
        chk("good_w1_done", 8'(bus.frame_done), 8'h01);
        tick(1'b0, 8'h00);
        chk("good_after_en", 8'(bus.wr_en), 8'h00);
        chk("good_no_err",   8'(n_err_seen), 8'h00);

        // Address wrap.
        q = {8'hA5, 8'hFF, 8'h02, 8'h33, 8'h44};
        send_bytes(q);
        tick(1'b1, 8'h8A);
        chk("wrap_w0_addr", bus.wr_addr, 8'hFF);
        chk("wrap_w0_data", bus.wr_data, 8'h33);
        tick(1'b0, 8'h00);
        chk("wrap_w1_addr", bus.wr_addr,        8'h00);
        chk("wrap_w1_data", bus.wr_data,        8'h44);
        chk("wrap_w1_done", 8'(bus.frame_done), 8'h01);
        tick(1'b0, 8'h00);

        // Bad checksum, then a good frame.
        q = {8'hA5, 8'h10, 8'h02, 8'h11, 8'h22};
        send_bytes(q);
        tick(1'b1, 8'h20);
        chk("bad_chk_err",  8'(bus.frame_err), 8'h01);
        chk("bad_chk_code", 8'(bus.err_code),  8'h01);
        chk("bad_chk_wr",   8'(bus.wr_en),     8'h00);
        tick(1'b0, 8'h00);
        chk("bad_chk_pulse", 8'(bus.frame_err), 8'h00);
        q = {8'hA5, 8'h10, 8'h02, 8'h11, 8'h22};
        send_bytes(q);
        tick(1'b1, 8'h21);
        chk("recover_w0_addr", bus.wr_addr, 8'h10);
        repeat (3) tick(1'b0, 8'h00);

        // Length errors: zero and MAX_LEN+1; trailing bytes ignored.
        q = {8'hA5, 8'h10};
        send_bytes(q);
        tick(1'b1, 8'h00);
        chk("len0_err",  8'(bus.frame_err), 8'h01);
        chk("len0_code", 8'(bus.err_code),  8'h02);
        chk("len0_busy", 8'(bus.busy),      8'h00);
        q = {8'h02, 8'h11, 8'h22, 8'h21};
        send_bytes(q);
        chk("len0_ignored", 8'(bus.busy), 8'h00);
        q = {8'hA5, 8'h10};
        send_bytes(q);
        tick(1'b1, 8'h11);
        chk("len17_err",  8'(bus.frame_err), 8'h01);
        chk("len17_code", 8'(bus.err_code),  8'h02);
        q = {8'h01, 8'h55, 8'h54};
        send_bytes(q);
        chk("len17_ignored", 8'(bus.busy), 8'h00);

        // Timeout after the ADDR byte.
        tick(1'b1, 8'hA5);
        tick(1'b1, 8'h10);
        k = 0;
        for (int i = 1; i <= 2 * TMO; i++) begin
            tick(1'b0, 8'h00);
            if (bus.frame_err === 1'b1) begin
                k = i;
                break;
            end
        end
        chk("tmo_cycle", 8'(k),             8'(TMO - 1));
        chk("tmo_code",  8'(bus.err_code),  8'h03);
        chk("tmo_busy",  8'(bus.busy),      8'h00);
        tick(1'b0, 8'h00);

        // Reset after the first write of a 4-byte frame.
        q = {8'hA5, 8'h20, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04};
        send_bytes(q);
        tick(1'b1, 8'h20);
        chk("rc_w0_addr", bus.wr_addr, 8'h20);
        chk("rc_w0_data", bus.wr_data, 8'h01);
        done_before = n_done_seen;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rc_wr_en",   8'(bus.wr_en),      8'h00);
        chk("rc_addr",    bus.wr_addr,        8'h00);
        chk("rc_data",    bus.wr_data,        8'h00);
        chk("rc_code",    8'(bus.err_code),   8'h00);
        chk("rc_busy",    8'(bus.busy),       8'h00);
        repeat (3) tick(1'b0, 8'h00);
        rst_n = 1'b1;
        repeat (6) tick(1'b0, 8'h00);
        chk("rc_no_done", 8'(n_done_seen - done_before), 8'h00);
        chk("rc_idle_en", 8'(bus.wr_en), 8'h00);

        // Randomized streams.
        repeat (150) rand_frame();
        repeat (MAXL + 4) tick(1'b0, 8'h00);
        chk("rand_done_seen", 8'(n_done_seen > done_before), 8'h01);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/uart_frame_ctrl.md
UART_FRAME_CTRL -- requirements
Module: uart_frame_ctrl

Interface
REQ-001 Parameter SYNC_BYTE, default 8'hA5: frame start marker.
REQ-002 Parameter MAX_LEN, default 16: maximum payload bytes per frame (range 1..255).
REQ-003 Parameter TIMEOUT_CLKS, default 20000: maximum i_Clock cycles allowed between consecutive bytes inside a frame.
REQ-004 Port i_Clock  input  1  sole clock; all logic rising-edge.
REQ-005 Port i_Reset_n  input  1  asynchronous, active-low reset.
REQ-006 Port i_Rx_DV  input  1  one-cycle byte-valid strobe from the UART receiver.
REQ-007 Port i_Rx_Byte  input  8  received byte; valid only while i_Rx_DV=1.
REQ-008 Port o_Wr_En  output  1  one-cycle register-write strobe.
REQ-009 Port o_Wr_Addr  output  8  write address.
REQ-010 Port o_Wr_Data  output  8  write data.
REQ-011 Port o_Frame_Done  output  1  one-cycle pulse marking a committed good frame.
REQ-012 Port o_Frame_Err  output  1  one-cycle pulse marking an aborted frame.
REQ-013 Port o_Err_Code  output  2  cause of the last error: 01 checksum, 10 length, 11 timeout; holds its value until the next error.
REQ-014 Port o_Busy  output  1  high in every state except IDLE.

Function
REQ-015 Frame format: SYNC, ADDR, LEN, DATA[LEN], CHK.
REQ-016 A frame is good when ADDR ^ LEN ^ DATA[0..LEN-1] ^ CHK == 8'h00.
REQ-017 States: IDLE, ADDR, LEN, DATA, CHK, COMMIT. All state changes occur only on an i_Rx_DV cycle, except the COMMIT exit and the timeout exit.
REQ-018 IDLE: a byte equal to SYNC_BYTE moves to ADDR. Any other byte is discarded with no error.
REQ-019 ADDR: latch the base address, seed the running XOR, move to LEN.
REQ-020 LEN: if 1 <= LEN <= MAX_LEN, latch LEN, fold it into the XOR, clear the payload index, and move to DATA.
REQ-021 LEN: otherwise, set o_Err_Code=10, pulse o_Frame_Err on the next cycle, and return to IDLE.
REQ-022 DATA: store the byte in the payload buffer at the current index, fold it into the XOR, and increment the index. Move to CHK after byte LEN.
REQ-023 CHK: if the XOR result is 0, move to COMMIT.
REQ-024 CHK: otherwise, set o_Err_Code=01, pulse o_Frame_Err on the next cycle, and return to IDLE. No writes are issued.
REQ-025 COMMIT: issue LEN consecutive o_Wr_En cycles, starting the cycle after the CHK strobe, with o_Wr_Addr = (ADDR+i) mod 256 and o_Wr_Data = DATA[i] for i = 0..LEN-1.
REQ-026 COMMIT: pulse o_Frame_Done in the same cycle as the last write, then return to IDLE.
REQ-027 i_Rx_DV during COMMIT: the byte is discarded, with no error and no effect on the writes.
REQ-028 Timeout: an inter-byte counter clears on every i_Rx_DV and counts in ADDR, LEN, DATA and CHK.
REQ-029 Timeout: when the counter reaches TIMEOUT_CLKS-1, set o_Err_Code=11, pulse o_Frame_Err, and return to IDLE. A byte strobe arriving in that same cycle takes priority and clears the counter.
REQ-030 A SYNC_BYTE value received mid-frame is treated as ordinary data; there is no resynchronisation.
REQ-031 o_Wr_En, o_Frame_Done and o_Frame_Err are never asserted together, except o_Wr_En with o_Frame_Done on the last write.
REQ-032 Counter widths: $clog2(MAX_LEN+1) bits for the index, $clog2(TIMEOUT_CLKS) bits for the timeout counter; address arithmetic is 8-bit wrap-around.

Reset
REQ-033 Asserting i_Reset_n low sets, asynchronously: state IDLE; all outputs 0 (o_Err_Code=00, o_Wr_Addr=00, o_Wr_Data=00); XOR, index and timeout counter 0.
REQ-034 Reset mid-frame or mid-COMMIT abandons the frame with no further writes or pulses; payload buffer contents need not be cleared.

Structure
REQ-035 Package uart_frame_pkg holds the state encoding constants, the error-code constants (ERR_NONE, ERR_CHK, ERR_LEN, ERR_TMO) and the default SYNC_BYTE.
REQ-036 The payload store is a sub-module uart_frame_buf: a MAX_LEN x 8 register file with one synchronous write port and one combinational read port, indexed by the payload index.

Verification
REQ-037 Good frame: A5 10 02 11 22 21 -> writes (10,11) then (11,22) in consecutive cycles; o_Frame_Done with the second write; o_Frame_Err never asserted.
REQ-038 Address wrap: A5 FF 02 33 44 8A -> writes (FF,33) then (00,44).
REQ-039 Bad checksum: A5 10 02 11 22 20 -> no o_Wr_En; one o_Frame_Err pulse; o_Err_Code=01; the next good frame succeeds.
REQ-040 Length errors: A5 10 00 and A5 10 11 (MAX_LEN=16) -> o_Err_Code=10 and o_Frame_Err each time; the following bytes are ignored until the next A5.
REQ-041 Timeout: A5 10, then no byte for TIMEOUT_CLKS cycles -> o_Frame_Err and o_Err_Code=11 at cycle TIMEOUT_CLKS-1 after the 10 strobe; o_Busy falls to 0.
REQ-042 Reset in COMMIT: i_Reset_n low after the first write of a 4-byte frame -> no further o_Wr_En; o_Frame_Done not pulsed; state IDLE; all outputs 0.
